// File: rtl/device_arbiter_rr.sv
// device_arbiter_rr: round-robin arbiter that connects N bus masters to one
// memory-mapped device on the cart's internal request/ack bus. The winning
// request goes into a registered command stage. An ack watchdog stops a
// silent device from holding the bus forever.
module device_arbiter_rr #(
    parameter int         NUM_CONTROLLERS = 2,
    parameter int         ADDRESS_WIDTH   = 25,
    parameter int         DATA_WIDTH      = 32,
    parameter logic [3:0] DEVICE_BANK     = 4'd1,
    parameter int         TIMEOUT         = 255
) (
    input  logic                                     i_clk,
    input  logic                                     i_reset_n,
    input  logic [NUM_CONTROLLERS-1:0]               i_request,
    input  logic [NUM_CONTROLLERS-1:0]               i_write,
    output logic [NUM_CONTROLLERS-1:0]               o_busy,
    output logic [NUM_CONTROLLERS-1:0]               o_ack,
    input  logic [4*NUM_CONTROLLERS-1:0]             i_bank,
    input  logic [ADDRESS_WIDTH*NUM_CONTROLLERS-1:0] i_address,
    input  logic [DATA_WIDTH*NUM_CONTROLLERS-1:0]    i_data,
    output logic [DATA_WIDTH*NUM_CONTROLLERS-1:0]    o_data,
    output logic                                     o_device_request,
    output logic                                     o_device_write,
    input  logic                                     i_device_busy,
    input  logic                                     i_device_ack,
    output logic [ADDRESS_WIDTH-1:0]                 o_device_address,
    output logic [DATA_WIDTH-1:0]                    o_device_data,
    input  logic [DATA_WIDTH-1:0]                    i_device_data,
    output logic                                     o_timeout
);

    localparam int N  = NUM_CONTROLLERS;
    localparam int AW = ADDRESS_WIDTH;
    localparam int DW = DATA_WIDTH;
    localparam int OW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_ACK = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   lastGrant_q, lastGrant_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic            cmdWrite_q, cmdWrite_d;
    logic [AW-1:0]   cmdAddress_q, cmdAddress_d;
    logic [DW-1:0]   cmdData_q, cmdData_d;
    logic [CW-1:0]   wdCount_q, wdCount_d;
    logic [N-1:0]    ack_q, ack_d;
    logic [DW*N-1:0] data_q, data_d;
    logic            timeout_q, timeout_d;

    logic [N-1:0]    eligible;
    logic [N-1:0]    probe;
    logic [OW-1:0]   grant;
    logic            anyEligible;
    logic            expired;

    // The watchdog fires on the last allowed WAIT_ACK cycle. A zero TIMEOUT turns it off.
    assign expired = (TIMEOUT != 0) && (wdCount_q == CW'(TIMEOUT - 1));

    // A controller competes only when it requests and addresses this device's bank
    always_comb begin
        eligible = '0;
        for (int i = 0; i < N; i++) begin
            eligible[i] = i_request[i] && (i_bank[4*i +: 4] == DEVICE_BANK);
        end
    end

    // Round-robin search that starts one past the last winner and takes the first eligible controller
    always_comb begin
        int idx;
        idx         = 0;
        probe       = '0;
        grant       = '0;
        anyEligible = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx   = (int'(lastGrant_q) + 1 + k) % N;
            probe = eligible >> idx;
            if (!anyEligible && probe[0]) begin
                grant       = OW'(idx);
                anyEligible = 1'b1;
            end
        end
    end

    // Every eligible controller is busy except the one granted in IDLE
    always_comb begin
        o_busy = '0;
        for (int i = 0; i < N; i++) begin
            o_busy[i] = eligible[i] && !((state_q == IDLE) && (grant == OW'(i)));
        end
    end

    // Next-state logic: accept into the command stage, hand the command to the device, then wait for an ack or a timeout
    always_comb begin
        state_d      = state_q;
        lastGrant_d  = lastGrant_q;
        owner_d      = owner_q;
        cmdWrite_d   = cmdWrite_q;
        cmdAddress_d = cmdAddress_q;
        cmdData_d    = cmdData_q;
        wdCount_d    = wdCount_q;
        ack_d        = '0;
        data_d       = '0;
        timeout_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (anyEligible) begin
                    state_d      = ISSUE;
                    lastGrant_d  = grant;
                    owner_d      = grant;
                    cmdWrite_d   = i_write[grant];
                    cmdAddress_d = i_address[grant*AW +: AW];
                    cmdData_d    = i_data[grant*DW +: DW];
                end
            end
            ISSUE: begin
                if (!i_device_busy) begin
                    state_d   = WAIT_ACK;
                    wdCount_d = '0;
                end
            end
            WAIT_ACK: begin
                if (i_device_ack) begin
                    state_d                   = IDLE;
                    ack_d[owner_q]            = 1'b1;
                    data_d[owner_q*DW +: DW]  = i_device_data;
                end else if (expired) begin
                    state_d                   = IDLE;
                    ack_d[owner_q]            = 1'b1;
                    data_d[owner_q*DW +: DW]  = '1;
                    timeout_d                 = 1'b1;
                end else begin
                    wdCount_d = wdCount_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and command registers. Reset drops any transaction in flight and gives controller 0 first priority.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= IDLE;
            lastGrant_q  <= OW'(N - 1);
            owner_q      <= '0;
            cmdWrite_q   <= 1'b0;
            cmdAddress_q <= '0;
            cmdData_q    <= '0;
            wdCount_q    <= '0;
            ack_q        <= '0;
            data_q       <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            lastGrant_q  <= lastGrant_d;
            owner_q      <= owner_d;
            cmdWrite_q   <= cmdWrite_d;
            cmdAddress_q <= cmdAddress_d;
            cmdData_q    <= cmdData_d;
            wdCount_q    <= wdCount_d;
            ack_q        <= ack_d;
            data_q       <= data_d;
            timeout_q    <= timeout_d;
        end
    end

    assign o_device_request = (state_q == ISSUE);
    assign o_device_write   = cmdWrite_q;
    assign o_device_address = cmdAddress_q;
    assign o_device_data    = cmdData_q;
    assign o_ack            = ack_q;
    assign o_data           = data_q;
    assign o_timeout        = timeout_q;

endmodule

// File: tb/tb_device_arbiter_rr.sv
// tb_device_arbiter_rr: directed scenarios and a randomized run of
// device_arbiter_rr. The randomized run is checked against a
// transaction-level reference model.
module tb_device_arbiter_rr;

    localparam int N  = 3;
    localparam int AW = 25;
    localparam int DW = 32;
    localparam int TO = 4;

    logic            clk;
    logic            rstN;
    logic [N-1:0]    req, wr, busy, ack;
    logic [4*N-1:0]  bank;
    logic [AW*N-1:0] addr;
    logic [DW*N-1:0] wdata, rdata;
    logic            devReq, devWr, devBusy, devAck, timeoutO;
    logic [AW-1:0]   devAddr;
    logic [DW-1:0]   devDout, devDin;

    int vecs;
    int errs;

    device_arbiter_rr #(
        .NUM_CONTROLLERS(N),
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH(DW),
        .DEVICE_BANK(4'd1),
        .TIMEOUT(TO)
    ) dut (
        .i_clk(clk),
        .i_reset_n(rstN),
        .i_request(req),
        .i_write(wr),
        .o_busy(busy),
        .o_ack(ack),
        .i_bank(bank),
        .i_address(addr),
        .i_data(wdata),
        .o_data(rdata),
        .o_device_request(devReq),
        .o_device_write(devWr),
        .i_device_busy(devBusy),
        .i_device_ack(devAck),
        .o_device_address(devAddr),
        .o_device_data(devDout),
        .i_device_data(devDin),
        .o_timeout(timeoutO)
    );

    // Free-running clock with a 10-unit period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the bench cannot hang
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

    task automatic idleInputs();
        req = '0; wr = '0; bank = '0; addr = '0; wdata = '0;
        devBusy = 1'b0; devAck = 1'b0; devDin = '0;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        idleInputs();
        rstN = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstN = 1'b1;
    endtask

    task automatic test_reset();
        idleInputs();
        rstN = 1'b0;
        req = 3'b011; bank = 12'h011;
        @(negedge clk);
        vecs++; if (busy !== 3'b010) begin errs++; $display("[TB] FAIL reset_busy: got %b want %b", busy, 3'b010); end
        vecs++; if (devReq !== 1'b0 || devWr !== 1'b0 || devAddr !== '0 || devDout !== '0) begin errs++; $display("[TB] FAIL reset_device: req %b wr %b addr %h data %h want all 0", devReq, devWr, devAddr, devDout); end
        vecs++; if (ack !== '0 || rdata !== '0 || timeoutO !== 1'b0) begin errs++; $display("[TB] FAIL reset_ack: ack %b data %h timeout %b want 0", ack, rdata, timeoutO); end
        @(negedge clk);
        vecs++; if (busy !== 3'b010 || devReq !== 1'b0) begin errs++; $display("[TB] FAIL reset_hold: busy %b req %b want 010 0", busy, devReq); end
        idleInputs();
    endtask

    task automatic test_single_read();
        doReset();
        req[0] = 1'b1; bank[3:0] = 4'd1; wr[0] = 1'b0; addr[24:0] = 25'h123; wdata[31:0] = 32'h1111;
        @(negedge clk);
        vecs++; if (busy !== 3'b000) begin errs++; $display("[TB] FAIL single_accept: busy %b want 000", busy); end
        nextCycle(); idleInputs();
        @(negedge clk);
        vecs++; if (devReq !== 1'b1 || devAddr !== 25'h123 || devWr !== 1'b0) begin errs++; $display("[TB] FAIL single_issue: req %b addr %h wr %b want 1 123 0", devReq, devAddr, devWr); end
        nextCycle();
        nextCycle(); devAck = 1'b1; devDin = 32'hDEADBEEF;
        @(negedge clk);
        vecs++; if (ack !== 3'b000) begin errs++; $display("[TB] FAIL single_early_ack: ack %b want 000", ack); end
        nextCycle(); devAck = 1'b0; devDin = '0;
        @(negedge clk);
        vecs++; if (ack !== 3'b001) begin errs++; $display("[TB] FAIL single_ack: ack %b want 001", ack); end
        vecs++; if (rdata[31:0] !== 32'hDEADBEEF || rdata[95:32] !== '0) begin errs++; $display("[TB] FAIL single_data: data %h want 0..0DEADBEEF", rdata); end
        nextCycle();
        @(negedge clk);
        vecs++; if (ack !== 3'b000 || rdata !== '0) begin errs++; $display("[TB] FAIL single_pulse: ack %b data %h want 0", ack, rdata); end
    endtask

    task automatic test_round_robin();
        logic [2:0] eb;
        logic [2:0] ea;
        doReset();
        req = 3'b111; bank = 12'h111;
        addr = {25'h102, 25'h101, 25'h100};
        for (int k = 0; k < 6; k++) begin
            eb = ~(3'b001 << (k % 3));
            @(negedge clk);
            vecs++; if (busy !== eb) begin errs++; $display("[TB] FAIL rr_grant_%0d: busy %b want %b", k, busy, eb); end
            if (k > 0) begin
                ea = 3'b001 << ((k - 1) % 3);
                vecs++; if (ack !== ea) begin errs++; $display("[TB] FAIL rr_ack_%0d: ack %b want %b", k, ack, ea); end
            end
            nextCycle();
            @(negedge clk);
            vecs++; if (busy !== 3'b111 || devReq !== 1'b1 || devAddr !== 25'(32'h100 + (k % 3))) begin errs++; $display("[TB] FAIL rr_issue_%0d: busy %b req %b addr %h", k, busy, devReq, devAddr); end
            nextCycle(); devAck = 1'b1; devDin = 32'(k);
            @(negedge clk);
            vecs++; if (busy !== 3'b111) begin errs++; $display("[TB] FAIL rr_wait_%0d: busy %b want 111", k, busy); end
            nextCycle(); devAck = 1'b0;
        end
        @(negedge clk);
        vecs++; if (ack !== 3'b100 || rdata[95:64] !== 32'd5) begin errs++; $display("[TB] FAIL rr_last_ack: ack %b data %h want 100 5", ack, rdata[95:64]); end
        idleInputs();
    endtask

    task automatic test_bank_filter();
        doReset();
        req[1] = 1'b1; bank[7:4] = 4'd2;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            vecs++; if (busy !== 3'b000 || devReq !== 1'b0 || ack !== 3'b000) begin errs++; $display("[TB] FAIL bank_filter_%0d: busy %b req %b ack %b want 000 0 000", k, busy, devReq, ack); end
            nextCycle();
        end
        idleInputs();
    endtask

    task automatic test_device_stall();
        doReset();
        req[2] = 1'b1; bank[11:8] = 4'd1; wr[2] = 1'b1; addr[74:50] = 25'h1ABCDE; wdata[95:64] = 32'hCAFEF00D;
        @(negedge clk);
        vecs++; if (busy !== 3'b000) begin errs++; $display("[TB] FAIL stall_accept: busy %b want 000", busy); end
        nextCycle();
        req[2] = 1'b0; wr[2] = 1'b0; addr[74:50] = '0; wdata[95:64] = '0; devBusy = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k == 5) devBusy = 1'b0;
            @(negedge clk);
            vecs++; if (devReq !== 1'b1 || devAddr !== 25'h1ABCDE || devDout !== 32'hCAFEF00D || devWr !== 1'b1) begin errs++; $display("[TB] FAIL stall_hold_%0d: req %b addr %h data %h wr %b", k, devReq, devAddr, devDout, devWr); end
            nextCycle();
        end
        devAck = 1'b1; devDin = 32'h55;
        @(negedge clk);
        vecs++; if (devReq !== 1'b0) begin errs++; $display("[TB] FAIL stall_release: req %b want 0", devReq); end
        nextCycle(); devAck = 1'b0;
        @(negedge clk);
        vecs++; if (ack !== 3'b100) begin errs++; $display("[TB] FAIL stall_ack: ack %b want 100", ack); end
    endtask

    task automatic test_watchdog();
        doReset();
        req[1] = 1'b1; bank[7:4] = 4'd1; addr[49:25] = 25'h77;
        @(negedge clk);
        vecs++; if (busy !== 3'b000) begin errs++; $display("[TB] FAIL wd_accept: busy %b want 000", busy); end
        nextCycle(); idleInputs();
        @(negedge clk);
        vecs++; if (devReq !== 1'b1) begin errs++; $display("[TB] FAIL wd_issue: req %b want 1", devReq); end
        for (int k = 2; k <= 5; k++) begin
            nextCycle();
            @(negedge clk);
            vecs++; if (ack !== 3'b000 || timeoutO !== 1'b0) begin errs++; $display("[TB] FAIL wd_quiet_%0d: ack %b timeout %b want 000 0", k, ack, timeoutO); end
        end
        nextCycle();
        @(negedge clk);
        vecs++; if (timeoutO !== 1'b1 || ack !== 3'b010) begin errs++; $display("[TB] FAIL wd_fire: timeout %b ack %b want 1 010", timeoutO, ack); end
        vecs++; if (rdata[63:32] !== 32'hFFFFFFFF || rdata[31:0] !== '0 || rdata[95:64] !== '0) begin errs++; $display("[TB] FAIL wd_data: data %h want 0 FFFFFFFF 0", rdata); end
        nextCycle(); devAck = 1'b1; devDin = 32'h1234;
        @(negedge clk);
        vecs++; if (ack !== 3'b000 || timeoutO !== 1'b0) begin errs++; $display("[TB] FAIL wd_pulse: ack %b timeout %b want 000 0", ack, timeoutO); end
        nextCycle(); devAck = 1'b0;
        @(negedge clk);
        vecs++; if (ack !== 3'b000 || rdata !== '0) begin errs++; $display("[TB] FAIL wd_stray: ack %b data %h want 0", ack, rdata); end
    endtask

    task automatic test_async_reset();
        doReset();
        req = 3'b001; bank[3:0] = 4'd1;
        @(negedge clk);
        nextCycle(); idleInputs(); devBusy = 1'b1;
        @(negedge clk);
        vecs++; if (devReq !== 1'b1) begin errs++; $display("[TB] FAIL arst_issue: req %b want 1", devReq); end
        rstN = 1'b0;
        #1;
        vecs++; if (devReq !== 1'b0) begin errs++; $display("[TB] FAIL arst_req_drop: req %b want 0", devReq); end
        devBusy = 1'b0;
        @(posedge clk); #1; rstN = 1'b1;
        devAck = 1'b1; devDin = 32'h99;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vecs++; if (ack !== 3'b000 || devReq !== 1'b0) begin errs++; $display("[TB] FAIL arst_no_ack_%0d: ack %b req %b want 000 0", k, ack, devReq); end
            nextCycle(); devAck = 1'b0;
        end
        req = 3'b001; bank[3:0] = 4'd1;
        @(negedge clk);
        nextCycle(); idleInputs();
        nextCycle(); devAck = 1'b1; devDin = 32'hA5A5A5A5;
        nextCycle(); devAck = 1'b0;
        @(negedge clk);
        vecs++; if (ack !== 3'b001) begin errs++; $display("[TB] FAIL arst_pre_ack: ack %b want 001", ack); end
        rstN = 1'b0;
        #1;
        vecs++; if (ack !== 3'b000 || rdata !== '0) begin errs++; $display("[TB] FAIL arst_ack_drop: ack %b data %h want 0", ack, rdata); end
        @(posedge clk); #1; rstN = 1'b1;
        req = 3'b011; bank = 12'h011;
        @(negedge clk);
        vecs++; if (busy !== 3'b010) begin errs++; $display("[TB] FAIL arst_first_grant: busy %b want 010", busy); end
        nextCycle(); idleInputs();
    endtask

    // Transaction-level model: the bus is free or owned, a command waits for the
    // device or has been taken, and completion times come from simple latency arithmetic
    task automatic test_random();
        int mLast, ackCycle, devAckCycle, owner, winner, idx, d;
        bit outstanding, issuing, expTo, free;
        logic [N-1:0] elig, probe, expBusy, expAck;
        logic [DW*N-1:0] expData;
        logic cWr;
        logic [AW-1:0] cAddr;
        logic [DW-1:0] cData, ackData, devRespData;
        doReset();
        mLast = N - 1; outstanding = 0; issuing = 0; ackCycle = -1; devAckCycle = -1;
        owner = 0; expTo = 0; cWr = 0; cAddr = '0; cData = '0; ackData = '0; devRespData = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                req[i] = ($urandom_range(0, 99) < 40);
                bank[4*i +: 4] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd1;
                wr[i] = 1'($urandom);
                addr[AW*i +: AW] = AW'($urandom);
                wdata[DW*i +: DW] = $urandom;
            end
            devBusy = ($urandom_range(0, 2) == 0);
            devAck = (c == devAckCycle);
            devDin = devAck ? devRespData : $urandom;

            free = !outstanding || (c == ackCycle);
            elig = '0;
            for (int i = 0; i < N; i++) elig[i] = req[i] && (bank[4*i +: 4] == 4'd1);
            winner = -1;
            for (int k = 0; k < N; k++) begin
                idx = (mLast + 1 + k) % N;
                probe = elig >> idx;
                if (winner < 0 && probe[0]) winner = idx;
            end
            expBusy = '0;
            for (int i = 0; i < N; i++) expBusy[i] = elig[i] && !(free && winner == i);
            expAck = '0; expData = '0;
            if (c == ackCycle) begin
                expAck = 3'(1 << owner);
                expData[DW*owner +: DW] = ackData;
            end

            @(negedge clk);
            vecs++; if (busy !== expBusy) begin errs++; $display("[TB] FAIL rnd_busy c%0d: got %b want %b", c, busy, expBusy); end
            vecs++; if (devReq !== issuing) begin errs++; $display("[TB] FAIL rnd_devreq c%0d: got %b want %b", c, devReq, issuing); end
            if (issuing) begin
                vecs++; if (devAddr !== cAddr || devDout !== cData || devWr !== cWr) begin errs++; $display("[TB] FAIL rnd_cmd c%0d: got %h %h %b want %h %h %b", c, devAddr, devDout, devWr, cAddr, cData, cWr); end
            end
            vecs++; if (ack !== expAck) begin errs++; $display("[TB] FAIL rnd_ack c%0d: got %b want %b", c, ack, expAck); end
            vecs++; if (rdata !== expData) begin errs++; $display("[TB] FAIL rnd_data c%0d: got %h want %h", c, rdata, expData); end
            vecs++; if (timeoutO !== (c == ackCycle && expTo)) begin errs++; $display("[TB] FAIL rnd_timeout c%0d: got %b want %b", c, timeoutO, (c == ackCycle && expTo)); end

            if (c == ackCycle) begin
                outstanding = 0;
                ackCycle = -1;
            end
            if (issuing && !devBusy) begin
                issuing = 0;
                d = $urandom_range(0, 5);
                devAckCycle = c + 1 + d;
                devRespData = $urandom;
                if (d <= TO - 1) begin
                    ackCycle = c + 2 + d; ackData = devRespData; expTo = 0;
                end else begin
                    ackCycle = c + 1 + TO; ackData = '1; expTo = 1;
                end
            end
            if (free && winner >= 0) begin
                outstanding = 1; issuing = 1; owner = winner; mLast = winner;
                probe = wr >> winner;
                cWr = probe[0];
                cAddr = addr[AW*winner +: AW];
                cData = wdata[DW*winner +: DW];
            end
            nextCycle();
        end
        idleInputs();
    endtask

    // Run the scenarios in order, then report
    initial begin
        vecs = 0;
        errs = 0;
        idleInputs();
        rstN = 1'b1;
        #3;
        test_reset();
        test_single_read();
        test_round_robin();
        test_bank_filter();
        test_device_stall();
        test_watchdog();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
